// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing a memory-mapped UART TX among  |
// |               NUM_REQ byte requesters. Acts as an AXI4-Lite master:      |
// |               polls status until tx idle, writes the byte, then waits a  |
// |               settle gap before the next poll.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int                    NUM_REQ       = 4,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int c_strb_w = DATA_WIDTH / 8;
  localparam int c_cnt_w  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_status_addr = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [c_cnt_w-1:0]    c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_strb_w-1:0]   c_strb_byte0  = c_strb_w'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POLL_AR = 3'd1,
    S_POLL_R  = 3'd2,
    S_WR      = 3'd3,
    S_WR_B    = 3'd4,
    S_SETTLE  = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_rr_ptr, w_rr_nxt;
  logic [7:0]            r_byte, w_byte_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]    r_req_ready, w_req_ready_nxt;
  logic [2:0]            r_grant_id, w_grant_nxt;
  logic                  r_busy, r_err, w_err_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic                  r_rready, w_rready_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [c_strb_w-1:0]   r_wstrb, w_wstrb_nxt;
  logic                  r_bready, w_bready_nxt;

  logic                  w_found;
  logic [2:0]            w_gnt;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [7:0]            w_gnt_byte;
  logic                  w_unused_rdata;

  // Only tx_active (bit 1) of the status word matters; rx-valid and the rest are ignored.
  assign w_unused_rdata = ^{m_axi_rdata[DATA_WIDTH-1:2], m_axi_rdata[0]};

  // Round-robin pick: first valid at or after rr_ptr, else first valid from index 0.
  always_comb begin
    w_found    = 1'b0;
    w_gnt      = 3'd0;
    w_gnt_oh   = '0;
    w_gnt_byte = 8'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid[j] && (j >= int'(r_rr_ptr))) begin
        w_found     = 1'b1;
        w_gnt       = 3'(j);
        w_gnt_oh[j] = 1'b1;
        w_gnt_byte  = req_data[8*j +: 8];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid[j]) begin
        w_found     = 1'b1;
        w_gnt       = 3'(j);
        w_gnt_oh[j] = 1'b1;
        w_gnt_byte  = req_data[8*j +: 8];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr_ptr;
    w_byte_nxt      = r_byte;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = '0;
    w_grant_nxt     = r_grant_id;
    w_err_nxt       = 1'b0;
    w_arvalid_nxt   = r_arvalid;
    w_araddr_nxt    = r_araddr;
    w_rready_nxt    = r_rready;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_bready_nxt    = r_bready;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_POLL_AR;
          w_req_ready_nxt = w_gnt_oh;
          w_grant_nxt     = w_gnt;
          w_byte_nxt      = w_gnt_byte;
          w_rr_nxt        = (int'(w_gnt) == NUM_REQ - 1) ? 3'd0 : w_gnt + 3'd1;
          w_arvalid_nxt   = 1'b1;
          w_araddr_nxt    = c_status_addr;
        end
      end
      S_POLL_AR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_POLL_R;
        end
      end
      S_POLL_R: begin
        if (m_axi_rvalid) begin
          w_rready_nxt = 1'b0;
          w_err_nxt    = (m_axi_rresp != 2'b00);
          // A failed status read is treated like a busy transmitter.
          if (m_axi_rdata[1] || (m_axi_rresp != 2'b00)) begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_POLL_AR;
          end else begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_wdata_nxt   = DATA_WIDTH'(r_byte);
            w_wstrb_nxt   = c_strb_byte0;
            w_state_nxt   = S_WR;
          end
        end
      end
      S_WR: begin
        if (m_axi_awready) w_awvalid_nxt = 1'b0;
        if (m_axi_wready)  w_wvalid_nxt  = 1'b0;
        if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (m_axi_bvalid) begin
          w_bready_nxt = 1'b0;
          w_err_nxt    = (m_axi_bresp != 2'b00);
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Gives the UART time to raise tx_active before it is polled again.
        if (r_cnt == c_settle_last) w_state_nxt = S_IDLE;
        else                        w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 3'd0;
      r_byte      <= 8'd0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_grant_id  <= 3'd0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= BASE_ADDR;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_byte      <= w_byte_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_grant_id  <= w_grant_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err       <= w_err_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_araddr    <= w_araddr_nxt;
      r_rready    <= w_rready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_bready    <= w_bready_nxt;
    end
  end

  assign req_ready     = r_req_ready;
  assign grant_id      = r_grant_id;
  assign busy          = r_busy;
  assign err           = r_err;
  assign m_axi_awaddr  = BASE_ADDR;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Bench for uart_tx_arbiter with an AXI4-Lite UART slave     |
// |               model and a write scoreboard.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int          NUM_REQ = 4;
  localparam logic [31:0] BASE    = 32'h4000_1000;
  localparam int          SETTLE  = 4;

  typedef struct packed { logic [2:0] gid; logic [7:0] data; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2:0]  grant_id;
  logic        busy, err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // slave model and requester state
  int   aw_dly, w_dly, b_dly, busy_left;
  logic [1:0] bresp_k;
  logic s_ar, s_r, s_aw, s_w, s_b, aw_got, w_got;
  int   aw_wait, w_wait, b_wait;
  int   pend [NUM_REQ];
  logic [7:0] byte_v [NUM_REQ];

  // monitor counters
  int ar_hs, aw_hs, w_hs, b_hs, err_cnt;
  int rdy_cnt [NUM_REQ];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(BASE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .err(err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [2:0] gid, input logic [7:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic pend_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (pend[i] > 0) r = 1'b1;
    return r;
  endfunction

  // One clock: update slave and requesters 2 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
    if (rst) begin
      rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0; b_wait = 0;
    end else begin
      if (s_r) rvalid = 1'b0;
      if (s_ar) begin
        rvalid = 1'b1;
        rdata  = (busy_left > 0) ? 32'h2 : 32'h0;
        if (busy_left > 0) busy_left--;
      end
      if (s_aw) begin aw_got = 1'b1; aw_wait = 0; end
      if (s_w)  begin w_got  = 1'b1; w_wait  = 0; end
      if (s_b)  begin aw_got = 1'b0; w_got = 1'b0; b_wait = 0; end
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] && pend[i] > 0) pend[i]--;
      awready = 1'b0;
      if (awvalid && !aw_got) begin awready = (aw_wait >= aw_dly); aw_wait++; end
      wready = 1'b0;
      if (wvalid && !w_got) begin wready = (w_wait >= w_dly); w_wait++; end
      bvalid = 1'b0;
      if (aw_got && w_got) begin bvalid = (b_wait >= b_dly); b_wait++; end
    end
    bresp   = bresp_k;
    rresp   = 2'b00;
    arready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = (pend[i] > 0);
      req_data[8*i +: 8] = byte_v[i];
    end
    s_ar = arvalid && arready;
    s_r  = rvalid && rready;
    s_aw = awvalid && awready;
    s_w  = wvalid && wready;
    s_b  = bvalid && bready;
  endtask

  task automatic run_idle(input int max, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    do begin
      step();
      n++;
      if (busy) busy_cyc++;
    end while ((busy || pend_any()) && n < max);
    if (busy || pend_any()) begin
      total++; bad++;
      $display("FAIL timeout: still busy after %0d cycles, expected idle", max);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_grant_id"}, grant_id, 0);
    chk({p, "_busy_err"}, {busy, err}, 2'b00);
    chk({p, "_valids"}, {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk({p, "_addrs"}, {awaddr, araddr}, {BASE, BASE});
    chk({p, "_wdata_wstrb"}, {wdata, wstrb}, 36'h0);
  endtask

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge.
  task automatic monitor();
    logic pa, pw, par, perr, last_busy;
    logic [31:0] pa_addr, pw_data, par_addr;
    logic [3:0] pw_strb;
    logic [NUM_REQ-1:0] prr;
    exp_t e;
    pa = 0; pw = 0; par = 0; perr = 0; prr = '0; last_busy = 1'b1;
    pa_addr = '0; pw_data = '0; par_addr = '0; pw_strb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa = 0; pw = 0; par = 0; perr = 0; prr = '0; last_busy = 1'b1;
      end else begin
        if (pa)  chk("aw_hold", {awvalid, awaddr}, {1'b1, pa_addr});
        if (pw)  chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, pw_data, pw_strb});
        if (par) chk("ar_hold", {arvalid, araddr}, {1'b1, par_addr});
        if (arvalid) chk("one_outstanding", {awvalid, wvalid, bready, rready}, 4'b0);
        if (arvalid && arready) begin
          ar_hs++;
          chk("araddr", araddr, BASE + 32'h4);
        end
        if (rvalid && rready) last_busy = rdata[1] | (rresp != 2'b00);
        if (awvalid && awready) begin
          aw_hs++;
          chk("awaddr", awaddr, BASE);
          chk("write_while_busy", last_busy, 1'b0);
        end
        if (wvalid && wready) begin
          w_hs++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got wdata %0h, expected no write", wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wdata", wdata, {24'h0, e.data});
            chk("wstrb", wstrb, 4'b0001);
            chk("grant_id", grant_id, e.gid);
          end
        end
        if (bvalid && bready) b_hs++;
        if (req_ready != '0) begin
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
          chk("req_ready_onehot", req_ready, 4'b0001 << grant_id);
          chk("req_ready_width", prr, 0);
          chk("req_ready_with_arvalid", arvalid, 1'b1);
        end
        if (err) begin
          err_cnt++;
          chk("err_width", perr, 1'b0);
        end
        pa = awvalid && !awready;  pa_addr  = awaddr;
        pw = wvalid && !wready;    pw_data  = wdata; pw_strb = wstrb;
        par = arvalid && !arready; par_addr = araddr;
        prr = req_ready;
        perr = err;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0, aw0, w0, b0, e0, r0, bc, n;
    rst = 1'b1; req_valid = '0; req_data = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 1; rvalid = 0; rdata = 0; rresp = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; busy_left = 0; bresp_k = 2'b00;
    s_ar = 0; s_r = 0; s_aw = 0; s_w = 0; s_b = 0; aw_got = 0; w_got = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; err_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; byte_v[i] = 8'h0; rdy_cnt[i] = 0; end
    fork
      monitor();
    join_none

    repeat (3) step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // single request from requester 2
    ar0 = ar_hs; w0 = w_hs; r0 = rdy_cnt[2]; e0 = err_cnt;
    byte_v[2] = 8'h41; pend[2] = 1; expect_wr(3'd2, 8'h41);
    run_idle(100, bc);
    chk("single_ar_count", ar_hs - ar0, 1);
    chk("single_w_count", w_hs - w0, 1);
    chk("single_ready_cycles", rdy_cnt[2] - r0, 1);
    chk("single_busy_cycles", bc, 4 + SETTLE);
    chk("single_no_err", err_cnt - e0, 0);

    // busy polling: three busy status reads
    ar0 = ar_hs; w0 = w_hs;
    busy_left = 3; byte_v[3] = 8'h55; pend[3] = 1; expect_wr(3'd3, 8'h55);
    run_idle(100, bc);
    chk("poll_ar_count", ar_hs - ar0, 4);
    chk("poll_w_count", w_hs - w0, 1);
    chk("poll_busy_cycles", bc, 4 + SETTLE + 6);

    // round robin with everyone valid
    w0 = w_hs;
    for (int i = 0; i < NUM_REQ; i++) begin byte_v[i] = 8'h10 + 8'(i); pend[i] = 1; end
    pend[0] = 2;
    expect_wr(3'd0, 8'h10); expect_wr(3'd1, 8'h11); expect_wr(3'd2, 8'h12);
    expect_wr(3'd3, 8'h13); expect_wr(3'd0, 8'h10);
    run_idle(200, bc);
    chk("rr_w_count", w_hs - w0, 5);

    // AXI backpressure
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    aw_dly = 3; w_dly = 1; b_dly = 5;
    byte_v[1] = 8'hA5; pend[1] = 1; expect_wr(3'd1, 8'hA5);
    run_idle(100, bc);
    chk("bp_aw_count", aw_hs - aw0, 1);
    chk("bp_w_count", w_hs - w0, 1);
    chk("bp_b_count", b_hs - b0, 1);
    chk("bp_busy_cycles", bc, 4 + SETTLE + 3 + 5);
    aw_dly = 0; w_dly = 0; b_dly = 0;

    // error response, then a normal transfer
    ar0 = ar_hs; w0 = w_hs; e0 = err_cnt;
    bresp_k = 2'b10; byte_v[2] = 8'h3C; pend[2] = 1; expect_wr(3'd2, 8'h3C);
    run_idle(100, bc);
    chk("err_pulses", err_cnt - e0, 1);
    chk("err_no_retry_w", w_hs - w0, 1);
    chk("err_no_retry_ar", ar_hs - ar0, 1);
    bresp_k = 2'b00; e0 = err_cnt; w0 = w_hs;
    byte_v[3] = 8'h7E; pend[3] = 1; expect_wr(3'd3, 8'h7E);
    run_idle(100, bc);
    chk("after_err_w", w_hs - w0, 1);
    chk("after_err_no_err", err_cnt - e0, 0);

    // reset while the write is stalled
    aw_dly = 20; w_dly = 20;
    byte_v[1] = 8'h99; pend[1] = 1;
    n = 0;
    do begin step(); n++; end while (!awvalid && n < 50);
    chk("reach_wr", awvalid, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk_reset("midreset");
    rst = 1'b0;
    aw_dly = 0; w_dly = 0;
    byte_v[0] = 8'h21; byte_v[2] = 8'h23; pend[0] = 1; pend[2] = 1;
    expect_wr(3'd0, 8'h21); expect_wr(3'd2, 8'h23);
    run_idle(200, bc);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
